updown_monitor: RTL and testbench

Passive observer on the 4-bit output of the up/down counter. It samples the count stream and decodes the direction of travel. It flags illegal steps, wraps and direction reversals, and keeps run-length and error statistics. It sits beside the counter in the sync up/down subsystem and is the consumer end of the counter's count/updown interface.

---
 rtl/updown_pkg.sv | 10 +
 rtl/updown_step_classifier.sv | 32 +++
 rtl/updown_monitor.sv | 139 +++++++++++++
 tb/tb_updown_monitor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared encodings for updown_monitor and its step classifier.
package updown_pkg;

   typedef enum logic [1:0] {S_INIT, S_SYNC, S_UP, S_DOWN} state_e;
   typedef enum logic [1:0] {CLS_UP, CLS_DOWN, CLS_HOLD, CLS_ERR} step_cls_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_step_classifier.sv
// Combinational step decoder: classifies count_in - prev (mod 2^WIDTH) and
// flags max->0 / 0->max wraps.
module updown_step_classifier
   import updown_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_prev,
   input  logic [WIDTH-1:0] i_count,
   output step_cls_e        o_cls,
   output logic             o_wrap
);

   logic [WIDTH-1:0] w_delta;

   assign w_delta = i_count - i_prev;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      o_cls = CLS_ERR;
      if (w_delta == WIDTH'(1))
         o_cls = CLS_UP;
      else if (w_delta == '1)
         o_cls = CLS_DOWN;
      else if (w_delta == '0)
         o_cls = CLS_HOLD;
   end

   assign o_wrap = ((o_cls == CLS_UP)   && (i_prev == '1) && (i_count == '0)) ||
                   ((o_cls == CLS_DOWN) && (i_prev == '0) && (i_count == '1));

endmodule

// File: rtl/updown_monitor.sv
// Passive up/down counter observer: direction decode, step/wrap/turn pulses,
// run-length and error statistics. UPDOWN_MON_STRICT_EN makes HOLD illegal while tracking.
module updown_monitor
   import updown_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int RUN_W = 8,
   parameter int ERR_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             valid_in,
   output logic             dir_out,
   output logic             dir_valid,
   output logic             step_err,
   output logic             wrap_pulse,
   output logic             turn_pulse,
   output logic [RUN_W-1:0] run_len,
   output logic [ERR_W-1:0] err_count
);

   state_e           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_prev, w_prev_nxt;
   logic             r_dir, w_dir_nxt;
   logic             r_dir_valid, w_dir_valid_nxt;
   logic             r_step_err, w_step_err_nxt;
   logic             r_wrap, w_wrap_nxt;
   logic             r_turn, w_turn_nxt;
   logic [RUN_W-1:0] r_run_len, w_run_nxt, w_run_inc;
   logic [ERR_W-1:0] r_err_count, w_err_nxt, w_err_inc;
   step_cls_e        w_cls;
   logic             w_wrap;
   logic             w_hold_err;

   updown_step_classifier #(.WIDTH(WIDTH)) u_classifier (
      .i_prev  (r_prev),
      .i_count (count_in),
      .o_cls   (w_cls),
      .o_wrap  (w_wrap)
   );

`ifdef UPDOWN_MON_STRICT_EN
   assign w_hold_err = 1'b1;
`else
   assign w_hold_err = 1'b0;
`endif

   assign w_run_inc = (r_run_len == '1)   ? r_run_len   : r_run_len + RUN_W'(1);
   assign w_err_inc = (r_err_count == '1) ? r_err_count : r_err_count + ERR_W'(1);

   always_comb begin
      w_state_nxt     = r_state;
      w_prev_nxt      = r_prev;
      w_dir_nxt       = r_dir;
      w_dir_valid_nxt = r_dir_valid;
      w_run_nxt       = r_run_len;
      w_err_nxt       = r_err_count;
      w_step_err_nxt  = 1'b0;
      w_wrap_nxt      = 1'b0;
      w_turn_nxt      = 1'b0;
      if (valid_in) begin
         // prev follows every sample, ERR included, so tracking resynchronises.
         w_prev_nxt = count_in;
         unique case (r_state)
            S_INIT: w_state_nxt = S_SYNC;
            S_SYNC: begin
               w_wrap_nxt = w_wrap;
               unique case (w_cls)
                  CLS_UP, CLS_DOWN: begin
                     w_state_nxt     = (w_cls == CLS_UP) ? S_UP : S_DOWN;
                     w_dir_nxt       = (w_cls == CLS_UP) ? DIR_UP : DIR_DOWN;
                     w_dir_valid_nxt = 1'b1;
                     w_run_nxt       = RUN_W'(1);
                  end
                  CLS_ERR: begin
                     w_step_err_nxt = 1'b1;
                     w_err_nxt      = w_err_inc;
                  end
                  CLS_HOLD: ;
               endcase
            end
            S_UP, S_DOWN: begin
               w_wrap_nxt = w_wrap;
               if ((w_cls == CLS_ERR) || ((w_cls == CLS_HOLD) && w_hold_err)) begin
                  w_step_err_nxt  = 1'b1;
                  w_err_nxt       = w_err_inc;
                  w_state_nxt     = S_SYNC;
                  w_dir_valid_nxt = 1'b0;
                  w_run_nxt       = '0;
               end else if (w_cls != CLS_HOLD) begin
                  if ((w_cls == CLS_UP) == (r_state == S_UP)) begin
                     w_run_nxt = w_run_inc;
                  end else begin
                     w_turn_nxt  = 1'b1;
                     w_state_nxt = (w_cls == CLS_UP) ? S_UP : S_DOWN;
                     w_dir_nxt   = (w_cls == CLS_UP) ? DIR_UP : DIR_DOWN;
                     w_run_nxt   = RUN_W'(1);
                  end
               end
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all update together at the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_INIT;
         r_prev      <= '0;
         r_dir       <= 1'b0;
         r_dir_valid <= 1'b0;
         r_step_err  <= 1'b0;
         r_wrap      <= 1'b0;
         r_turn      <= 1'b0;
         r_run_len   <= '0;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_prev      <= w_prev_nxt;
         r_dir       <= w_dir_nxt;
         r_dir_valid <= w_dir_valid_nxt;
         r_step_err  <= w_step_err_nxt;
         r_wrap      <= w_wrap_nxt;
         r_turn      <= w_turn_nxt;
         r_run_len   <= w_run_nxt;
         r_err_count <= w_err_nxt;
      end
   end

   assign dir_out    = r_dir;
   assign dir_valid  = r_dir_valid;
   assign step_err   = r_step_err;
   assign wrap_pulse = r_wrap;
   assign turn_pulse = r_turn;
   assign run_len    = r_run_len;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_updown_monitor.sv
// Directed testbench for updown_monitor; observed outputs are packed as
// {dir_valid, dir_out, step_err, wrap_pulse, turn_pulse, run_len, err_count}.
module tb_updown_monitor;

   logic       clock;
   logic       reset;
   logic [3:0] count_in;
   logic       valid_in;
   logic       dir_out, dir_valid, step_err, wrap_pulse, turn_pulse;
   logic [7:0] run_len;
   logic [7:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;

   updown_monitor #(.WIDTH(4), .RUN_W(8), .ERR_W(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .count_in   (count_in),
      .valid_in   (valid_in),
      .dir_out    (dir_out),
      .dir_valid  (dir_valid),
      .step_err   (step_err),
      .wrap_pulse (wrap_pulse),
      .turn_pulse (turn_pulse),
      .run_len    (run_len),
      .err_count  (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [20:0] obs();
      return {dir_valid, dir_out, step_err, wrap_pulse, turn_pulse, run_len, err_count};
   endfunction

   function automatic logic [20:0] exp_v(input bit dv, input bit dir, input bit se,
                                         input bit wp, input bit tp, input int run, input int err);
      return {dv, dir, se, wp, tp, 8'(run), 8'(err)};
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset    = 1'b1;
      valid_in = 1'b0;
      count_in = 4'd0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Drive one valid sample; returns just after the capturing edge.
   task automatic sample(input int v);
      @(negedge clock);
      count_in = 4'(v);
      valid_in = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      @(negedge clock);
      valid_in = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      valid_in = 1'b0;
      count_in = 4'd0;
      #1;
      n_cmp++;
      if (obs() !== exp_v(0, 0, 0, 0, 0, 0, 0)) begin
         n_bad++;
         $display("FAIL reset got %h expected %h", obs(), exp_v(0, 0, 0, 0, 0, 0, 0));
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_up_count();
      logic [20:0] e;
      do_reset();
      for (int i = 0; i <= 5; i++) begin
         sample(i);
         e = (i == 0) ? exp_v(0, 0, 0, 0, 0, 0, 0) : exp_v(1, 1, 0, 0, 0, i, 0);
         n_cmp++;
         if (obs() !== e) begin
            n_bad++;
            $display("FAIL up_count[%0d] got %h expected %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_wrap();
      int v[5] = '{13, 14, 15, 0, 1};
      logic [20:0] e[5];
      e = '{exp_v(0, 0, 0, 0, 0, 0, 0), exp_v(1, 1, 0, 0, 0, 1, 0), exp_v(1, 1, 0, 0, 0, 2, 0),
            exp_v(1, 1, 0, 1, 0, 3, 0), exp_v(1, 1, 0, 0, 0, 4, 0)};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sample(v[i]);
         n_cmp++;
         if (obs() !== e[i]) begin
            n_bad++;
            $display("FAIL wrap[%0d] got %h expected %h", i, obs(), e[i]);
         end
      end
   endtask

   task automatic test_wrap_turn();
      int v[3] = '{0, 15, 0};
      logic [20:0] e[3];
      e = '{exp_v(0, 0, 0, 0, 0, 0, 0), exp_v(1, 0, 0, 1, 0, 1, 0), exp_v(1, 1, 0, 1, 1, 1, 0)};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         sample(v[i]);
         n_cmp++;
         if (obs() !== e[i]) begin
            n_bad++;
            $display("FAIL wrap_turn[%0d] got %h expected %h", i, obs(), e[i]);
         end
      end
   endtask

   task automatic test_turn();
      int v[5] = '{7, 8, 9, 8, 7};
      logic [20:0] e[5];
      e = '{exp_v(0, 0, 0, 0, 0, 0, 0), exp_v(1, 1, 0, 0, 0, 1, 0), exp_v(1, 1, 0, 0, 0, 2, 0),
            exp_v(1, 0, 0, 0, 1, 1, 0), exp_v(1, 0, 0, 0, 0, 2, 0)};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sample(v[i]);
         n_cmp++;
         if (obs() !== e[i]) begin
            n_bad++;
            $display("FAIL turn[%0d] got %h expected %h", i, obs(), e[i]);
         end
      end
   endtask

   // -1 marks an idle (valid_in=0) cycle.
   task automatic test_step_err();
      int v[5] = '{3, 4, 9, -1, 10};
      logic [20:0] e[5];
      e = '{exp_v(0, 0, 0, 0, 0, 0, 0), exp_v(1, 1, 0, 0, 0, 1, 0), exp_v(0, 1, 1, 0, 0, 0, 1),
            exp_v(0, 1, 0, 0, 0, 0, 1), exp_v(1, 1, 0, 0, 0, 1, 1)};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (v[i] < 0) idle();
         else sample(v[i]);
         n_cmp++;
         if (obs() !== e[i]) begin
            n_bad++;
            $display("FAIL step_err[%0d] got %h expected %h", i, obs(), e[i]);
         end
      end
   endtask

   task automatic test_hold();
      int v[5] = '{2, 2, 3, 3, 4};
      logic [20:0] e[5];
`ifdef UPDOWN_MON_STRICT_EN
      e = '{exp_v(0, 0, 0, 0, 0, 0, 0), exp_v(0, 0, 0, 0, 0, 0, 0), exp_v(1, 1, 0, 0, 0, 1, 0),
            exp_v(0, 1, 1, 0, 0, 0, 1), exp_v(1, 1, 0, 0, 0, 1, 1)};
`else
      e = '{exp_v(0, 0, 0, 0, 0, 0, 0), exp_v(0, 0, 0, 0, 0, 0, 0), exp_v(1, 1, 0, 0, 0, 1, 0),
            exp_v(1, 1, 0, 0, 0, 1, 0), exp_v(1, 1, 0, 0, 0, 2, 0)};
`endif
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sample(v[i]);
         n_cmp++;
         if (obs() !== e[i]) begin
            n_bad++;
            $display("FAIL hold[%0d] got %h expected %h", i, obs(), e[i]);
         end
      end
   endtask

   // Live up/down counter starting at 12; direction flips every 8 steps.
   task automatic test_live_counter();
      int v, prev;
      bit up, exp_wp, exp_tp;
      logic [20:0] e;
      do_reset();
      v    = 12;
      prev = 12;
      up   = 1'b1;
      for (int i = 0; i < 48; i++) begin
         if (i > 0) begin
            prev = v;
            up   = (((i - 1) / 8) % 2) == 0;
            v    = (up ? v + 1 : v + 15) % 16;
         end
         sample(v);
         exp_wp = (i > 0) && ((up && prev == 15 && v == 0) || (!up && prev == 0 && v == 15));
         exp_tp = (i >= 9) && (((i - 1) % 8) == 0);
         e = (i == 0) ? exp_v(0, 0, 0, 0, 0, 0, 0)
                      : exp_v(1, up, 0, exp_wp, exp_tp, ((i - 1) % 8) + 1, 0);
         n_cmp++;
         if (obs() !== e) begin
            n_bad++;
            $display("FAIL live[%0d] got %h expected %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_err_saturate();
      logic [20:0] e;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         sample((i % 2) ? 8 : 0);
         e = (i == 0) ? exp_v(0, 0, 0, 0, 0, 0, 0)
                      : exp_v(0, 0, 1, 0, 0, 0, (i < 255) ? i : 255);
         n_cmp++;
         if (obs() !== e) begin
            n_bad++;
            $display("FAIL err_sat[%0d] got %h expected %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_run_saturate();
      logic [20:0] e;
      do_reset();
      for (int i = 0; i < 259; i++) begin
         sample(i % 16);
         e = (i == 0) ? exp_v(0, 0, 0, 0, 0, 0, 0)
                      : exp_v(1, 1, 0, (i % 16) == 0, 0, (i < 255) ? i : 255, 0);
         n_cmp++;
         if (obs() !== e) begin
            n_bad++;
            $display("FAIL run_sat[%0d] got %h expected %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i <= 6; i++) sample(i);
      n_cmp++;
      if (obs() !== exp_v(1, 1, 0, 0, 0, 6, 0)) begin
         n_bad++;
         $display("FAIL mid_reset_pre got %h expected %h", obs(), exp_v(1, 1, 0, 0, 0, 6, 0));
      end
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== exp_v(0, 0, 0, 0, 0, 0, 0)) begin
         n_bad++;
         $display("FAIL mid_reset_async got %h expected %h", obs(), exp_v(0, 0, 0, 0, 0, 0, 0));
      end
      #1 reset = 1'b0;
      sample(11);
      n_cmp++;
      if (obs() !== exp_v(0, 0, 0, 0, 0, 0, 0)) begin
         n_bad++;
         $display("FAIL mid_reset_init got %h expected %h", obs(), exp_v(0, 0, 0, 0, 0, 0, 0));
      end
      sample(12);
      n_cmp++;
      if (obs() !== exp_v(1, 1, 0, 0, 0, 1, 0)) begin
         n_bad++;
         $display("FAIL mid_reset_sync got %h expected %h", obs(), exp_v(1, 1, 0, 0, 0, 1, 0));
      end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_wrap();
      test_wrap_turn();
      test_turn();
      test_step_err();
      test_hold();
      test_live_counter();
      test_err_saturate();
      test_run_saturate();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
